// File: rtl/sopc_pkg.sv
// Shared definitions for the min SOPC: bus FSM states, Wishbone widths and reset levels.
// Reset levels match RstEnable/RstDisable in defines.svh.
package sopc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } wb_state_t;

    localparam int WbDataW = 32;
    localparam int WbSelW  = 4;

    localparam logic RstEnable  = 1'b1;
    localparam logic RstDisable = 1'b0;

endpackage

// File: rtl/wb_data_ram_slave_byte_ram.sv
// Byte-lane RAM with one 8-bit array per lane and a registered read port.
// Each lane has its own write enable.
module byte_ram
    import sopc_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [WbSelW-1:0]     be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WbDataW-1:0]    wdata,
    output logic [WbDataW-1:0]    rdata
);

    localparam int Depth = 2 ** ADDR_WIDTH;

    for (genvar i = 0; i < WbSelW; i++) begin : g_lane
        logic [7:0] mem [Depth];
        logic [7:0] rd_q;

        // NOTE: storage has no reset, so it maps onto block RAM; contents survive rst.
        always_ff @(posedge clk) begin
            if (we && be[i]) begin
                mem[addr] <= wdata[8*i +: 8];
            end
            rd_q <= mem[addr];
        end

        assign rdata[8*i +: 8] = rd_q;
    end

endmodule

// File: rtl/wb_data_ram_slave.sv
// Wishbone classic-cycle data RAM slave for the OpenMIPS data bus.
// Adds programmable wait states, and the master can abort a transfer during the wait states.
module wb_data_ram_slave
    import sopc_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [31:0]        wb_adr_i,
    input  logic [WbSelW-1:0]  wb_sel_i,
    input  logic [WbDataW-1:0] wb_dat_i,
    output logic [WbDataW-1:0] wb_dat_o,
    output logic               wb_ack_o
);

    localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    wb_state_t             state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [WbSelW-1:0]     sel_q, sel_d;
    logic [WbDataW-1:0]    wdat_q, wdat_d;
    logic                  ack_q, ack_d;
    logic                  rd_done_q, rd_done_d;
    logic [WbDataW-1:0]    rdat_q, rdat_d;

    logic                  acc_go;
    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic [WbSelW-1:0]     acc_sel;
    logic [WbDataW-1:0]    acc_dat;
    logic [WbDataW-1:0]    ram_rdata;

    logic unused_adr;
    assign unused_adr = ^{wb_adr_i[31:ADDR_WIDTH+2], wb_adr_i[1:0]};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        we_d       = we_q;
        idx_d      = idx_q;
        sel_d      = sel_q;
        wdat_d     = wdat_q;

        unique case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    we_d   = wb_we_i;
                    idx_d  = wb_adr_i[ADDR_WIDTH+1:2];
                    sel_d  = wb_sel_i;
                    wdat_d = wb_dat_i;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ACK;
                    end else begin
                        wait_cnt_d = WaitLoad;
                        state_d    = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (wait_cnt_q == 4'd0) begin
                    state_d = ACK;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With no wait states the access happens on the capture edge itself, so take it from the bus.
    always_comb begin
        acc_we  = we_q;
        acc_idx = idx_q;
        acc_sel = sel_q;
        acc_dat = wdat_q;
        if (state_q == IDLE) begin
            acc_we  = wb_we_i;
            acc_idx = wb_adr_i[ADDR_WIDTH+1:2];
            acc_sel = wb_sel_i;
            acc_dat = wb_dat_i;
        end
        acc_go    = (state_d == ACK);
        ack_d     = acc_go;
        rd_done_d = acc_go && !acc_we;
        rdat_d    = rd_done_q ? ram_rdata : rdat_q;
    end

    byte_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (acc_go && acc_we),
        .be    (acc_sel),
        .addr  (acc_idx),
        .wdata (acc_dat),
        .rdata (ram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            we_q       <= 1'b0;
            idx_q      <= '0;
            sel_q      <= '0;
            wdat_q     <= '0;
            ack_q      <= 1'b0;
            rd_done_q  <= 1'b0;
            rdat_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            we_q       <= we_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            wdat_q     <= wdat_d;
            ack_q      <= ack_d;
            rd_done_q  <= rd_done_d;
            rdat_q     <= rdat_d;
        end
    end

    // The RAM output is live only in a read's ACK cycle; afterwards the held copy drives the bus.
    assign wb_dat_o = rd_done_q ? ram_rdata : rdat_q;
    assign wb_ack_o = ack_q;

endmodule
